// File: rtl/instruction_segment_register_pkg.sv
// Shared CPU constants for the instruction segment register.
// The top-level CPU passes these into the register's WIDTH and RESET_VALUE.
package instruction_segment_register_pkg;

    localparam int          ISR_WIDTH       = 16;
    localparam logic [15:0] ISR_RESET_VALUE = 16'h0000;

endpackage

// File: rtl/instruction_segment_register.sv
// Instruction segment base register feeding fetch-address formation.
// Holds the last loaded segment and flags whether a load has happened since reset and whether the last load changed the value.
module instruction_segment_register
    import instruction_segment_register_pkg::*;
#(
    parameter int               WIDTH       = ISR_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(ISR_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_isr,
    input  logic [WIDTH-1:0] isr_data_in,
    output logic [WIDTH-1:0] isr_data_out,
    output logic             isr_valid,
    output logic             isr_updated
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_updated;
    logic             w_changed;

    assign w_changed = (isr_data_in != r_data);

    // All three flop groups reset together; reset always wins over a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data    <= RESET_VALUE;
            r_valid   <= 1'b0;
            r_updated <= 1'b0;
        end else if (load_isr) begin
            r_data    <= isr_data_in;
            r_valid   <= 1'b1;
            r_updated <= w_changed;
        end else begin
            r_updated <= 1'b0;
        end
    end

    assign isr_data_out = r_data;
    assign isr_valid    = r_valid;
    assign isr_updated  = r_updated;

endmodule

// File: tb/tb_instruction_segment_register.sv
// Randomized self-checking bench for instruction_segment_register.
// Expectations come from a transaction-level model updated by the stimulus tasks.
module tb_instruction_segment_register;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         load_isr;
    logic [W-1:0] isr_data_in;
    logic [W-1:0] isr_data_out;
    logic         isr_valid;
    logic         isr_updated;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // behavioural model: current segment, whether any load seen, whether last edge changed it
    logic [W-1:0] m_seg;
    logic         m_loaded;
    logic         m_changed;

    instruction_segment_register #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_isr     (load_isr),
        .isr_data_in  (isr_data_in),
        .isr_data_out (isr_data_out),
        .isr_valid    (isr_valid),
        .isr_updated  (isr_updated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seg     = 16'h0000;
        m_loaded  = 1'b0;
        m_changed = 1'b0;
    endtask

    // Drive one cycle of stimulus, let one rising edge pass, advance the model.
    task automatic step(input logic ld, input logic [W-1:0] d);
        load_isr    = ld;
        isr_data_in = d;
        @(posedge clk);
        if (reset) begin
            m_changed = ld && (d != m_seg);
            if (ld) begin
                m_seg    = d;
                m_loaded = 1'b1;
            end
        end
        #2;
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #1 reset = 1'b0;
        model_reset();
        #1;
        check({tag, "_data"},  32'(isr_data_out), 32'h0000);
        check({tag, "_valid"}, 32'(isr_valid),    32'h0);
        check({tag, "_upd"},   32'(isr_updated),  32'h0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_data",  32'(isr_data_out), 32'(m_seg));
            check("cyc_valid", 32'(isr_valid),    32'(m_loaded));
            check("cyc_upd",   32'(isr_updated),  32'(m_changed));
        end
    end

    initial begin
        reset       = 1'b0;
        load_isr    = 1'b1;
        isr_data_in = 16'hFFFF;
        model_reset();
        chk_en = 1;

        // reset held with an active load: nothing may be captured
        repeat (3) step(1'b1, 16'hFFFF);
        check("rst_data",  32'(isr_data_out), 32'h0000);
        check("rst_valid", 32'(isr_valid),    32'h0);

        reset = 1'b1;
        step(1'b1, 16'hABCD);
        check("load_data",  32'(isr_data_out), 32'hABCD);
        check("load_valid", 32'(isr_valid),    32'h1);
        check("load_upd",   32'(isr_updated),  32'h1);
        step(1'b0, 16'h1234);
        check("pulse_end",  32'(isr_updated),  32'h0);
        repeat (3) step(1'b0, 16'h1234);
        check("hold_data",  32'(isr_data_out), 32'hABCD);

        step(1'b1, 16'h5678);
        check("reload_data", 32'(isr_data_out), 32'h5678);
        check("reload_upd",  32'(isr_updated),  32'h1);
        repeat (5) step(1'b0, $urandom());
        check("reload_hold", 32'(isr_data_out), 32'h5678);

        step(1'b1, 16'h5678);
        check("same_data", 32'(isr_data_out), 32'h5678);
        check("same_upd",  32'(isr_updated),  32'h0);
        check("same_valid", 32'(isr_valid),   32'h1);

        // back-to-back changing loads keep the pulse high
        step(1'b1, 16'h0001);
        step(1'b1, 16'h0002);
        check("b2b_data", 32'(isr_data_out), 32'h0002);
        check("b2b_upd",  32'(isr_updated),  32'h1);

        step(1'b1, 16'h5678);
        async_reset("async");
        step(1'b1, 16'h9999);
        check("rst_wins", 32'(isr_data_out), 32'h0000);
        reset = 1'b1;
        // first edge after release may load; loading the reset value is not a change
        step(1'b1, 16'h0000);
        check("rel_valid", 32'(isr_valid),   32'h1);
        check("rel_upd",   32'(isr_updated), 32'h0);

        // randomized phase; small value pool makes same-value loads common
        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 3) == 0) ? m_seg : W'($urandom_range(0, 7) * 16'h1111);
            step(($urandom_range(0, 2) != 0), d);
            if ($urandom_range(0, 60) == 0) begin
                async_reset("rnd_rst");
                step(1'b1, $urandom());
                reset = 1'b1;
            end
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
